// File: rtl/display_scan_decoder.sv
// rtl/display_scan_decoder.sv - receive-side decoder for a multiplexed seven-segment display scan
//
// Purpose: samples scanned anode/segment lines, decodes each digit into a BCD slot,
//          assembles a full frame and converts it back to a 27-bit binary number.
// Ports:
//   clk          in   1                 system clock, rising edge
//   rst_n        in   1                 asynchronous active-low reset
//   anode        in   NUM_DIGITS        digit enables, anode[0] = least significant digit
//   seg          in   7                 segment lines {g,f,e,d,c,b,a}
//   number       out  27                last good decoded value
//   frame_valid  out  1                 one-cycle pulse: number has just been updated
//   frame_error  out  1                 one-cycle pulse: completed frame had an undecodable digit
//   digits_bcd   out  4*NUM_DIGITS      last good frame as BCD nibbles, [3:0] = digit 0
module display_scan_decoder #(
   parameter int NUM_DIGITS    = 8,
   parameter int ACTIVE_LOW    = 1,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_DIGITS-1:0]   anode,
   input  logic [6:0]              seg,
   output logic [26:0]             number,
   output logic                    frame_valid,
   output logic                    frame_error,
   output logic [4*NUM_DIGITS-1:0] digits_bcd
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

   localparam logic [1:0] ST_CAPTURE = 2'd0;
   localparam logic [1:0] ST_CONVERT = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   logic [NUM_DIGITS-1:0]   an;
   logic [NUM_DIGITS-1:0]   an_prev;
   logic [6:0]              sg;
   logic [CNT_W-1:0]        settle_cnt;
   logic [NUM_DIGITS-1:0]   seen;
   logic [NUM_DIGITS-1:0]   bad;
   logic [4*NUM_DIGITS-1:0] slots;
   logic [4*NUM_DIGITS-1:0] snap;
   logic                    frame_bad;
   logic [26:0]             acc;
   logic [IDX_W-1:0]        idx;
   logic [1:0]              state;

   logic                    stable;
   logic                    one_hot;
   logic                    sample;
   logic [4:0]              dec;
   logic [3:0]              cur_digit;

   // Returns {bad, value}; blank (all segments off) is a suppressed leading zero.
   function automatic logic [4:0] decode(input logic [6:0] c);
      case (c)
         7'h3F:   decode = 5'h00;
         7'h06:   decode = 5'h01;
         7'h5B:   decode = 5'h02;
         7'h4F:   decode = 5'h03;
         7'h66:   decode = 5'h04;
         7'h6D:   decode = 5'h05;
         7'h7D:   decode = 5'h06;
         7'h07:   decode = 5'h07;
         7'h7F:   decode = 5'h08;
         7'h6F:   decode = 5'h09;
         7'h00:   decode = 5'h00;
         default: decode = 5'h10;
      endcase
   endfunction

   always_comb begin
      an        = (ACTIVE_LOW != 0) ? ~anode : anode;
      sg        = (ACTIVE_LOW != 0) ? ~seg : seg;
      stable    = (an == an_prev);
      one_hot   = (an != '0) && ((an & (an - NUM_DIGITS'(1))) == '0);
      // Fires once per activation: the cycle the counter steps onto SETTLE_CYCLES.
      sample    = stable && (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) && one_hot;
      dec       = decode(sg);
      cur_digit = snap[{idx, 2'b00} +: 4];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_prev     <= '0;
         settle_cnt  <= '0;
         seen        <= '0;
         bad         <= '0;
         slots       <= '0;
         snap        <= '0;
         frame_bad   <= 1'b0;
         acc         <= '0;
         idx         <= '0;
         state       <= ST_CAPTURE;
         number      <= '0;
         digits_bcd  <= '0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         an_prev     <= an;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;

         if (!stable) begin
            settle_cnt <= '0;
         end else if (settle_cnt != CNT_W'(SETTLE_CYCLES)) begin
            settle_cnt <= settle_cnt + CNT_W'(1);
         end

         case (state)
            ST_CAPTURE: begin
               if (&seen) begin
                  snap      <= slots;
                  seen      <= '0;
                  bad       <= '0;
                  frame_bad <= |bad;
                  acc       <= '0;
                  idx       <= IDX_W'(NUM_DIGITS - 1);
                  state     <= ST_CONVERT;
               end
            end
            ST_CONVERT: begin
               // Horner evaluation from the most significant digit down.
               acc <= acc * 27'd10 + {23'd0, cur_digit};
               if (idx == '0) begin
                  state <= ST_DONE;
               end else begin
                  idx <= idx - IDX_W'(1);
               end
            end
            ST_DONE: begin
               if (frame_bad) begin
                  frame_error <= 1'b1;
               end else begin
                  number      <= acc;
                  digits_bcd  <= snap;
                  frame_valid <= 1'b1;
               end
               state <= ST_CAPTURE;
            end
            default: state <= ST_CAPTURE;
         endcase

         // Placed after the FSM so a sample landing on the snapshot edge keeps its slot bits.
         if (sample) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (an[i]) begin
                  slots[i*4 +: 4] <= dec[3:0];
                  seen[i]         <= 1'b1;
                  bad[i]          <= dec[4];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_display_scan_decoder.sv
// tb/tb_display_scan_decoder.sv - self-checking bench for display_scan_decoder
module tb_display_scan_decoder;

   localparam int SETTLE = 4;
   localparam int LAT    = 10;
   localparam logic [6:0] CODES [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  anode = 8'hFF;
   logic [6:0]  seg = 7'h7F;
   logic [26:0] number;
   logic        frame_valid;
   logic        frame_error;
   logic [31:0] digits_bcd;

   display_scan_decoder #(.NUM_DIGITS(8), .ACTIVE_LOW(1), .SETTLE_CYCLES(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .anode(anode), .seg(seg), .number(number),
      .frame_valid(frame_valid), .frame_error(frame_error), .digits_bcd(digits_bcd)
   );

   always #5 clk = ~clk;

   int edges = 0;
   always @(posedge clk) edges <= edges + 1;

   int errors = 0;
   int checks = 0;
   int n_valid = 0;
   int n_err = 0;

   typedef struct {
      int          at_edge;
      bit          good;
      logic [26:0] num;
      logic [31:0] bcd;
   } ev_t;
   ev_t evq[$];

   logic [3:0]  m_slot [8];
   logic [7:0]  m_seen = '0;
   logic [7:0]  m_bad = '0;
   logic [7:0]  m_prev_an = '0;
   logic [26:0] exp_number = '0;
   logic [31:0] exp_bcd = '0;
   bit          ev_now, ev_good;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edges);
      end
   endtask

   // Frame-level model: record the digit value at its sample edge, and once every
   // position has been seen predict the pulse and the decimal value of the frame.
   task automatic model_sample(input logic [7:0] an_int, input logic [6:0] code, input int s);
      int k = 0;
      bit found = (code == 7'h00);
      int val = 0;
      longint num = 0;
      longint p = 1;
      logic [31:0] bcd = '0;
      ev_t ev;
      for (int i = 0; i < 8; i++) if (an_int[i]) k = i;
      for (int d = 0; d < 10; d++) if (CODES[d] == code) begin found = 1; val = d; end
      m_slot[k] = 4'(val);
      m_bad[k]  = !found;
      m_seen[k] = 1'b1;
      if (m_seen == 8'hFF) begin
         for (int i = 0; i < 8; i++) begin
            num = num + longint'(m_slot[i]) * p;
            p = p * 10;
            bcd[i*4 +: 4] = m_slot[i];
         end
         ev.at_edge = s + LAT;
         ev.good    = (m_bad == 8'h00);
         ev.num     = 27'(num);
         ev.bcd     = bcd;
         evq.push_back(ev);
         m_seen = '0;
         m_bad  = '0;
      end
   endtask

   task automatic drive(input logic [7:0] an_int, input logic [6:0] code, input int hold);
      @(posedge clk);
      #1;
      anode = ~an_int;
      seg   = ~code;
      if (hold >= SETTLE + 1 && an_int != m_prev_an && $onehot(an_int))
         model_sample(an_int, code, edges + SETTLE + 1);
      m_prev_an = an_int;
      repeat (hold - 1) @(posedge clk);
   endtask

   task automatic scan_digit(input int k, input logic [6:0] code, input int hold);
      logic [7:0] one = 8'd1;
      drive(one << k, code, hold);
   endtask

   task automatic scan_frame(input logic [31:0] bcd, input logic [7:0] blank, input int bad_k);
      logic [6:0] code;
      for (int k = 0; k < 8; k++) begin
         if (blank[k]) code = 7'h00;
         else if (k == bad_k) code = 7'h49;
         else code = CODES[bcd[k*4 +: 4]];
         scan_digit(k, code, 10);
      end
   endtask

   task automatic gap(input int n);
      drive(8'h00, 7'h00, n);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         ev_now  = (evq.size() > 0) && (evq[0].at_edge == edges);
         ev_good = ev_now && evq[0].good;
         if (ev_now) begin
            if (evq[0].good) begin
               exp_number = evq[0].num;
               exp_bcd    = evq[0].bcd;
            end
            void'(evq.pop_front());
         end
         check("frame_valid", frame_valid, ev_now && ev_good);
         check("frame_error", frame_error, ev_now && !ev_good);
         check("number", number, exp_number);
         check("digits_bcd", digits_bcd, exp_bcd);
         if (frame_valid) n_valid++;
         if (frame_error) n_err++;
      end
   end

   initial begin
      #1;
      check("reset number", number, 27'd0);
      check("reset bcd", digits_bcd, 32'd0);
      check("reset valid", frame_valid, 1'b0);
      check("reset error", frame_error, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      scan_frame(32'h12345678, 8'h00, -1);
      gap(20);
      check("lit 12345678 number", number, 27'h0BC614E);
      check("lit 12345678 bcd", digits_bcd, 32'h12345678);
      check("lit valid count 1", n_valid, 1);

      scan_frame(32'h00000042, 8'hFC, -1);
      gap(20);
      check("lit blank number", number, 27'd42);
      check("lit blank bcd", digits_bcd, 32'h00000042);

      scan_frame(32'h99999999, 8'h00, -1);
      gap(20);
      check("lit 99999999 number", number, 27'h5F5E0FF);
      scan_frame(32'h00000000, 8'h00, -1);
      gap(20);
      check("lit zero number", number, 27'd0);
      check("lit valid count 4", n_valid, 4);

      scan_frame(32'h12345678, 8'h00, -1);
      scan_frame(32'h12345678, 8'h00, 3);
      gap(20);
      check("lit bad number held", number, 27'h0BC614E);
      check("lit bad bcd held", digits_bcd, 32'h12345678);
      check("lit error count", n_err, 1);
      check("lit valid count 5", n_valid, 5);

      for (int k = 0; k < 6; k++) scan_digit(k, CODES[k + 1], 10);
      scan_digit(6, CODES[7], 3);
      drive(8'b0000_0011, CODES[7], 6);
      scan_digit(7, CODES[8], 10);
      gap(20);
      check("lit glitch no pulse", n_valid, 5);
      scan_digit(6, CODES[7], 10);
      gap(20);
      check("lit glitch number", number, 27'h5397FB1);
      check("lit valid count 6", n_valid, 6);

      scan_frame(32'h12345678, 8'h00, -1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midconv reset number", number, 27'd0);
      check("midconv reset valid", frame_valid, 1'b0);
      check("midconv reset bcd", digits_bcd, 32'd0);
      evq.delete();
      exp_number = '0;
      exp_bcd    = '0;
      m_seen     = '0;
      m_bad      = '0;
      m_prev_an  = '0;
      anode      = 8'hFF;
      seg        = 7'h7F;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      gap(20);
      check("lit aborted no pulse", n_valid, 6);
      scan_frame(32'h24681357, 8'h00, -1);
      gap(20);
      check("lit after reset number", number, 27'h1789B8D);
      check("lit valid count 7", n_valid, 7);
      check("model queue drained", evq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
